rgb_dither_pipe: RTL and testbench
==================================

Name: rgb_dither_pipe

Overview:
Parametrised, pipelined ordered-dither stage between the renderer's multi-bit colour output and a narrower DAC/pin bus. It generalises the fixed 2-bit-to-1-bit, 2x2 field dither to configurable channel count and input/output depth, using a 4x4 Bayer threshold matrix. It adds selectable temporal modulation driven by a synchronously detected frame counter, and sync/DE signals delayed to match the pixel latency.

Parameters:
CHANNELS, 3, number of colour channels; channel 0 occupies the LSBs (RR in BBGGRR order).
IN_BITS, 2, bits per channel on input.
OUT_BITS, 1, bits per channel on output; constraint 1 <= IN_BITS-OUT_BITS <= 4.

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous, active-low reset
mode  in  2  0=truncate, 1=static Bayer, 2=temporal Bayer, 3=reserved (behaves as 1)
hsync_n  in  1  horizontal sync, pipelined through
vsync_n  in  1  vertical sync, pipelined through; its falling edge advances the frame counter
de  in  1  display enable (visible pixel)
xlo  in  2  hpos[1:0]
ylo  in  2  vpos[1:0]
rgb_in  in  CHANNELS*IN_BITS  packed pixel colour
rgb_out  out  CHANNELS*OUT_BITS  dithered colour
hsync_n_out  out  1  hsync_n delayed 2 cycles
vsync_n_out  out  1  vsync_n delayed 2 cycles
de_out  out  1  de delayed 2 cycles
frame  out  2  current frame counter

Behaviour:
- Reset (asynchronous, reset_n=0): rgb_out=0, de_out=0, hsync_n_out=1, vsync_n_out=1, frame=0, mode shadow=0, and all pipeline registers cleared with syncs held at 1.
- Latency: exactly 2 clocks from every input to its output, for all signals. There are no bubbles and no handshake; the pipe advances every clock.
- Stage 1 registers the inputs, computes the Bayer index and registers the threshold t (4 bits).
- Stage 2 computes per-channel output and registers it.
- Frame counter:
  - vsync_n is registered once. A 1->0 transition of the registered value increments frame by 1, mod 4.
  - A held-low vsync_n counts once.
- Mode shadow: mode is sampled into a shadow register on the same cycle the frame counter increments. The shadow is used for all pixels, so a mode change takes effect only at a frame boundary.
- Bayer matrix B[y][x], rows y=0..3:
  - y=0: 0 8 2 10
  - y=1: 12 4 14 6
  - y=2: 3 11 1 9
  - y=3: 15 7 13 5
- Index selection:
  - Static mode: (x,y) = (xlo, ylo).
  - Temporal mode: x = (xlo + frame) mod 4, y = (ylo + {frame[0],frame[1]}) mod 4.
- Per channel, with D = IN_BITS-OUT_BITS:
  - q = v >> D, f = v[D-1:0], fs = f << (4-D), giving 0..15.
  - Truncate mode: out = q.
  - Bayer modes: out = q + 1 if fs > t and q < 2^OUT_BITS-1; otherwise out = q (saturating).
  - f=0 never increments.
- Blanking: if the stage-2 de is 0, rgb_out = 0, regardless of rgb_in.
- Channels are independent and use the same t for a given pixel.
- Reset asserted mid-frame clears the pipeline immediately. The first valid output appears 2 clocks after reset_n rises, with frame=0 and mode shadow=0 (truncate) until the first vsync fall.

Test Plan:
- Reset and latency: hold reset_n=0 and check rgb_out=0, syncs=1, frame=0. Release, drive a de/hsync_n/vsync_n pattern and check the outputs reproduce it exactly 2 clocks later.
- Mode 1, defaults, rgb_in=6'b010101 (all channels 01), de=1, sweep xlo/ylo over 4x4 -> rgb_out=3'b111 at the 8 positions with t<8, e.g. (0,0) t=0 gives 111 and (1,0) t=8 gives 000. Exactly 8 of 16 are lit.
- Saturation and exact levels, mode 1: channel value 11 -> 1 everywhere; 10 -> 1 everywhere; 00 -> 0 everywhere.
- Mode 0: values 01, 10, 11 -> 0, 1, 1 at all positions.
- Temporal and mode shadowing:
  - Drive mode=2 and one vsync_n fall; check frame=1 and mode 2 is active.
  - At xlo=0, ylo=0: index (1,2), t=11, so value 01 -> 0.
  - After a second fall (frame=2): index (2,1), t=14, so value 01 -> 0.
  - Changing mode mid-frame has no effect until the next vsync fall.
- Blanking and reset mid-frame: de=0 with rgb_in=6'b111111 -> rgb_out=0.
- Assert reset_n=0 mid-line -> outputs clear in the same cycle, asynchronously.

Source files
------------

// File: rtl/rgb_dither_pipe.sv
// Two-stage ordered-dither pipe: multi-bit colour to a narrower DAC bus
// with 4x4 Bayer thresholds, optional temporal rotation and delayed syncs.
module rgb_dither_pipe #(
   parameter int CHANNELS = 3,
   parameter int IN_BITS  = 2,
   parameter int OUT_BITS = 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [1:0]                   mode,
   input  logic                         hsync_n,
   input  logic                         vsync_n,
   input  logic                         de,
   input  logic [1:0]                   xlo,
   input  logic [1:0]                   ylo,
   input  logic [CHANNELS*IN_BITS-1:0]  rgb_in,
   output logic [CHANNELS*OUT_BITS-1:0] rgb_out,
   output logic                         hsync_n_out,
   output logic                         vsync_n_out,
   output logic                         de_out,
   output logic [1:0]                   frame
);

   localparam int D  = IN_BITS - OUT_BITS;
   localparam int IW = CHANNELS * IN_BITS;
   localparam int OW = CHANNELS * OUT_BITS;

   localparam logic [3:0] BAYER [16] = '{
      4'd0,  4'd8,  4'd2,  4'd10,
      4'd12, 4'd4,  4'd14, 4'd6,
      4'd3,  4'd11, 4'd1,  4'd9,
      4'd15, 4'd7,  4'd13, 4'd5
   };

   logic [IW-1:0] rgb_s1_q, rgb_s1_d;
   logic          de_s1_q, de_s1_d;
   logic          hs_s1_q, hs_s1_d;
   logic          vs_s1_q, vs_s1_d;
   logic [3:0]    t_q, t_d;
   logic [OW-1:0] rgb_out_q, rgb_out_d;
   logic          de_s2_q, de_s2_d;
   logic          hs_s2_q, hs_s2_d;
   logic          vs_s2_q, vs_s2_d;
   logic [1:0]    frame_q, frame_d;
   logic [1:0]    mode_q, mode_d;

   logic          fall;
   logic [1:0]    bx, by;
   logic [OW-1:0] dith;

   always_comb begin
      fall    = vs_s2_q & ~vs_s1_q;
      frame_d = frame_q;
      mode_d  = mode_q;
      if (fall) begin
         frame_d = frame_q + 2'd1;
         mode_d  = mode;
      end
      bx = xlo;
      by = ylo;
      if (mode_q == 2'd2) begin
         bx = xlo + frame_q;
         by = ylo + {frame_q[0], frame_q[1]};
      end
      // Truncate uses t=15: no fraction can exceed it, so nothing rounds up.
      t_d      = (mode_q == 2'd0) ? 4'hf : BAYER[{by, bx}];
      rgb_s1_d = rgb_in;
      de_s1_d  = de;
      hs_s1_d  = hsync_n;
      vs_s1_d  = vsync_n;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [IN_BITS-1:0]  v;
      logic [OUT_BITS-1:0] q;
      logic [3:0]          fs;
      logic                inc;
      always_comb begin
         v   = rgb_s1_q[c*IN_BITS +: IN_BITS];
         q   = v[IN_BITS-1:D];
         fs  = 4'(v[D-1:0]) << (4 - D);
         inc = (fs > t_q) && (q != '1);
      end
      assign dith[c*OUT_BITS +: OUT_BITS] = inc ? q + OUT_BITS'(1) : q;
   end

   always_comb begin
      rgb_out_d = de_s1_q ? dith : '0;
      de_s2_d   = de_s1_q;
      hs_s2_d   = hs_s1_q;
      vs_s2_d   = vs_s1_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rgb_s1_q  <= '0;
         de_s1_q   <= 1'b0;
         hs_s1_q   <= 1'b1;
         vs_s1_q   <= 1'b1;
         t_q       <= '0;
         rgb_out_q <= '0;
         de_s2_q   <= 1'b0;
         hs_s2_q   <= 1'b1;
         vs_s2_q   <= 1'b1;
         frame_q   <= '0;
         mode_q    <= '0;
      end else begin
         rgb_s1_q  <= rgb_s1_d;
         de_s1_q   <= de_s1_d;
         hs_s1_q   <= hs_s1_d;
         vs_s1_q   <= vs_s1_d;
         t_q       <= t_d;
         rgb_out_q <= rgb_out_d;
         de_s2_q   <= de_s2_d;
         hs_s2_q   <= hs_s2_d;
         vs_s2_q   <= vs_s2_d;
         frame_q   <= frame_d;
         mode_q    <= mode_d;
      end
   end

   assign rgb_out     = rgb_out_q;
   assign hsync_n_out = hs_s2_q;
   assign vsync_n_out = vs_s2_q;
   assign de_out      = de_s2_q;
   assign frame       = frame_q;

endmodule

// File: tb/tb_rgb_dither_pipe.sv
// Bench for rgb_dither_pipe: directed Bayer/temporal/blanking cases plus
// random traffic against a cycle-level arithmetic reference model.
module tb_rgb_dither_pipe;

   localparam int CH = 3;
   localparam int IB = 2;
   localparam int OB = 1;
   localparam int D  = IB - OB;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [1:0]       mode = 2'd0;
   logic             hsync_n = 1'b1;
   logic             vsync_n = 1'b1;
   logic             de = 1'b0;
   logic [1:0]       xlo = 2'd0;
   logic [1:0]       ylo = 2'd0;
   logic [CH*IB-1:0] rgb_in = '0;
   logic [CH*OB-1:0] rgb_out;
   logic             hsync_n_out;
   logic             vsync_n_out;
   logic             de_out;
   logic [1:0]       frame;

   rgb_dither_pipe #(
      .CHANNELS(CH),
      .IN_BITS (IB),
      .OUT_BITS(OB)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mode       (mode),
      .hsync_n    (hsync_n),
      .vsync_n    (vsync_n),
      .de         (de),
      .xlo        (xlo),
      .ylo        (ylo),
      .rgb_in     (rgb_in),
      .rgb_out    (rgb_out),
      .hsync_n_out(hsync_n_out),
      .vsync_n_out(vsync_n_out),
      .de_out     (de_out),
      .frame      (frame)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   int bay [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

   // reference model state
   int m_frame, m_shadow, m_vr1, m_vr2;
   int s1_rgb, s1_de, s1_hs, s1_vs;
   int o_rgb, o_de, o_hs, o_vs;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int dither(int pix, int t, int md);
      int r, v, q, f, fs, o;
      r = 0;
      for (int c = 0; c < CH; c++) begin
         v  = (pix >> (c * IB)) & ((1 << IB) - 1);
         q  = v >> D;
         f  = v & ((1 << D) - 1);
         fs = f * (1 << (4 - D));
         o  = q;
         if (md != 0 && fs > t && q < (1 << OB) - 1) o = q + 1;
         r = r | (o << (c * OB));
      end
      return r;
   endfunction

   task automatic model_reset();
      m_frame = 0; m_shadow = 0; m_vr1 = 1; m_vr2 = 1;
      s1_rgb = 0; s1_de = 0; s1_hs = 1; s1_vs = 1;
      o_rgb = 0; o_de = 0; o_hs = 1; o_vs = 1;
   endtask

   task automatic model_edge();
      int x, y, t, md;
      o_rgb = s1_rgb; o_de = s1_de; o_hs = s1_hs; o_vs = s1_vs;
      md = (m_shadow == 3) ? 1 : m_shadow;
      x = int'(xlo);
      y = int'(ylo);
      if (md == 2) begin
         x = (x + m_frame) % 4;
         y = (y + (m_frame % 2) * 2 + m_frame / 2) % 4;
      end
      t = bay[y * 4 + x];
      s1_rgb = de ? dither(int'(rgb_in), t, md) : 0;
      s1_de = int'(de); s1_hs = int'(hsync_n); s1_vs = int'(vsync_n);
      if (m_vr2 == 1 && m_vr1 == 0) begin
         m_frame  = (m_frame + 1) % 4;
         m_shadow = int'(mode);
      end
      m_vr2 = m_vr1;
      m_vr1 = int'(vsync_n);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("rgb", 32'(rgb_out), 32'(o_rgb));
      check("de", 32'(de_out), 32'(o_de));
      check("hs", 32'(hsync_n_out), 32'(o_hs));
      check("vs", 32'(vsync_n_out), 32'(o_vs));
      check("frame", 32'(frame), 32'(m_frame));
   endtask

   task automatic vsync_fall(input logic [1:0] md);
      mode = md;
      vsync_n = 1'b0;
      repeat (3) cycle();
      vsync_n = 1'b1;
      repeat (3) cycle();
   endtask

   task automatic pixel(input logic [1:0] x, input logic [1:0] y,
                        input logic [CH*IB-1:0] p, output int o);
      de = 1'b1; xlo = x; ylo = y; rgb_in = p;
      cycle();
      cycle();
      o = int'(rgb_out);
   endtask

   task automatic sweep(input logic [CH*IB-1:0] p, input int target,
                        output int cnt, output int at00, output int at10);
      int o;
      cnt = 0; at00 = -1; at10 = -1;
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 4; x++) begin
            pixel(2'(x), 2'(y), p, o);
            if (o == target) cnt++;
            if (x == 0 && y == 0) at00 = o;
            if (x == 1 && y == 0) at10 = o;
         end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      check("rst_rgb", 32'(rgb_out), 32'd0);
      check("rst_de", 32'(de_out), 32'd0);
      check("rst_hs", 32'(hsync_n_out), 32'd1);
      check("rst_vs", 32'(vsync_n_out), 32'd1);
      check("rst_frame", 32'(frame), 32'd0);
      model_reset();
      @(negedge clk);
      de = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1; mode = 2'd0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int cnt, a, b, o;
      model_reset();
      @(negedge clk);
      do_reset();

      // sync/de pattern right after reset
      for (int i = 0; i < 8; i++) begin
         de = 1'(i % 3 == 0);
         hsync_n = 1'(i % 4 != 1);
         vsync_n = 1'(i != 5);
         rgb_in = 6'(i * 7);
         cycle();
      end
      vsync_n = 1'b1;
      repeat (3) cycle();

      vsync_fall(2'd1);
      sweep(6'b010101, 7, cnt, a, b);
      check("s1_lit_cnt", 32'(cnt), 32'd8);
      check("s1_00", 32'(a), 32'd7);
      check("s1_10", 32'(b), 32'd0);
      sweep(6'b111111, 7, cnt, a, b);
      check("s1_sat11", 32'(cnt), 32'd16);
      sweep(6'b101010, 7, cnt, a, b);
      check("s1_lvl10", 32'(cnt), 32'd16);
      sweep(6'b000000, 0, cnt, a, b);
      check("s1_lvl00", 32'(cnt), 32'd16);

      vsync_fall(2'd0);
      sweep(6'b010101, 0, cnt, a, b);
      check("m0_01", 32'(cnt), 32'd16);
      sweep(6'b101010, 7, cnt, a, b);
      check("m0_10", 32'(cnt), 32'd16);
      sweep(6'b111111, 7, cnt, a, b);
      check("m0_11", 32'(cnt), 32'd16);

      // temporal modulation and frame-boundary mode shadowing
      do_reset();
      vsync_fall(2'd2);
      check("tmp_frame1", 32'(frame), 32'd1);
      pixel(2'd0, 2'd0, 6'b010101, o);
      check("tmp_f1_00", 32'(o), 32'd0);
      pixel(2'd3, 2'd2, 6'b010101, o);
      check("tmp_f1_32", 32'(o), 32'd7);
      vsync_fall(2'd2);
      check("tmp_frame2", 32'(frame), 32'd2);
      pixel(2'd0, 2'd0, 6'b010101, o);
      check("tmp_f2_00", 32'(o), 32'd0);
      mode = 2'd0;
      pixel(2'd2, 2'd3, 6'b010101, o);
      check("tmp_f2_shadow", 32'(o), 32'd7);

      // blanking
      de = 1'b0; rgb_in = 6'b111111;
      cycle();
      cycle();
      check("blank", 32'(rgb_out), 32'd0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         mode = 2'($urandom_range(0, 3));
         hsync_n = 1'($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 39) == 0) vsync_n = ~vsync_n;
         de = 1'($urandom_range(0, 3) != 0);
         xlo = 2'($urandom);
         ylo = 2'($urandom);
         rgb_in = 6'($urandom);
         cycle();
      end

      // asynchronous reset in the middle of a lit line
      vsync_n = 1'b1;
      repeat (2) cycle();
      vsync_fall(2'd1);
      de = 1'b1; xlo = 2'd0; ylo = 2'd0; rgb_in = 6'b111111;
      cycle();
      cycle();
      check("pre_rst_rgb", 32'(rgb_out), 32'd7);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rgb", 32'(rgb_out), 32'd0);
      check("async_de", 32'(de_out), 32'd0);
      check("async_hs", 32'(hsync_n_out), 32'd1);
      check("async_vs", 32'(vsync_n_out), 32'd1);
      check("async_frame", 32'(frame), 32'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      // truncate until the first vsync fall: 01 stays dark at t=0 cell
      pixel(2'd0, 2'd0, 6'b010101, o);
      check("post_rst_trunc", 32'(o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
